// File: rtl/data_mem_responder.sv
// Purpose : single-port 16-bit word memory slave with a fixed-latency ready/err handshake.
// Latency : ready (and err, rdata) arrive 1+W clock edges after the request is sampled.
// Backpressure: none; requests seen while busy=1 are ignored, so the requester holds until ready.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous active-low reset; clears FSM, outputs and every memory word
//   mem_read_en   read request, sampled only in IDLE
//   mem_write_en  write request, sampled only in IDLE
//   addr[15:0]    word address; bits above ADDR_W must be zero for a legal access
//   wdata[15:0]   write data
//   rdata[15:0]   registered read data, held until the next completed read
//   ready         one-cycle completion pulse
//   busy          high while the FSM is outside IDLE
//   err           one-cycle pulse with ready for out-of-range or read+write requests
//
// Build option: define WAIT_STATE_EN to insert WAIT_CYCLES wait states per access
// (W = WAIT_CYCLES). Without it W = 0 and the WAIT state and its counter do not exist.

module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;

    // Parameter legality is checked at elaboration so a bad build never reaches silicon.
    if (ADDR_W < 1 || ADDR_W > 16 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_params
        $error("data_mem_responder: ADDR_W must be 1..16 and WAIT_CYCLES 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        req;
    logic        accept;
    logic        lat_rd;
    logic        lat_wr;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        oob;
    logic        conflict;

    logic [15:0] mem [DEPTH];

    assign req    = mem_read_en | mem_write_en;
    assign accept = (state == IDLE) && req;

`ifdef WAIT_STATE_EN
    // Counter holds the number of WAIT cycles still to go after the current one.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef WAIT_STATE_EN
                    state_nxt = (WAIT_CYCLES != 0) ? WAIT : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
`ifdef WAIT_STATE_EN
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Request capture: only IDLE looks at the request inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
        end else if (accept) begin
            lat_rd    <= mem_read_en;
            lat_wr    <= mem_write_en;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    assign oob      = (lat_addr >> ADDR_W) != 16'h0000;
    assign conflict = lat_rd & lat_wr;

    // Commit happens on the edge that leaves RESP, so a reset sampled while in
    // WAIT or RESP discards the access before anything is written or signalled.
    // A read+write request wins over out-of-range: it leaves rdata untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 16'h0000;
            ready <= 1'b0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (state == RESP) begin
                ready <= 1'b1;
                if (conflict) begin
                    err <= 1'b1;
                end else if (oob) begin
                    err <= 1'b1;
                    if (lat_rd) begin
                        rdata <= 16'h0000;
                    end
                end else if (lat_wr) begin
                    mem[lat_addr[ADDR_W-1:0]] <= lat_wdata;
                end else begin
                    rdata <= mem[lat_addr[ADDR_W-1:0]];
                end
            end
        end
    end

endmodule
